// File: rtl/mux2_rr_arbiter_4bit_pkg.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter_4bit_pkg
// Shared definitions for the two-requester round-robin arbiter:
//   SRC_0 / SRC_1   : source encodings, also used as the mux select value
//   cnt_width()     : width of the burst counter, which must hold 0..BURST
// -----------------------------------------------------------------------------
package mux2_rr_arbiter_4bit_pkg;

    localparam logic SRC_0 = 1'b0;
    localparam logic SRC_1 = 1'b1;

    // The counter saturates at BURST, so it needs to represent BURST itself.
    function automatic int cnt_width(input int burst);
        return (burst < 1) ? 1 : $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_4bit_if.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter_4bit_if
// Bundles the two requester valid/ready/data channels and the output
// valid/ready/data/src channel of the arbiter.
//   master : the environment side (producers and the downstream consumer)
//   slave  : the arbiter side
// -----------------------------------------------------------------------------
interface mux2_rr_arbiter_4bit_if;

    logic       req0_valid;
    logic [3:0] req0_data;
    logic       req0_ready;

    logic       req1_valid;
    logic [3:0] req1_data;
    logic       req1_ready;

    logic       out_valid;
    logic [3:0] out_data;
    logic       out_src;
    logic       out_ready;

    modport master (
        output req0_valid,
        output req0_data,
        input  req0_ready,
        output req1_valid,
        output req1_data,
        input  req1_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        output out_ready
    );

    modport slave (
        input  req0_valid,
        input  req0_data,
        output req0_ready,
        input  req1_valid,
        input  req1_data,
        output req1_ready,
        output out_valid,
        output out_data,
        output out_src,
        input  out_ready
    );

endinterface

// File: rtl/mux2_rr_arbiter_4bit_mux2by1.sv
// -----------------------------------------------------------------------------
// mux2by1_4bit
// Plain 4-bit 2:1 multiplexer.
//   op : select, 0 picks a, 1 picks b
//   a  : word from requester 0
//   b  : word from requester 1
//   y  : selected word
// -----------------------------------------------------------------------------
module mux2by1_4bit (
    input  logic       op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);

    assign y = op ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter_4bit.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter_4bit
// Burst-limited round-robin arbiter between two valid/ready producers feeding a
// single registered valid/ready output stage. The winning requester drives the
// select of a mux2by1_4bit; the selected word is captured with its source id.
//   BURST : max consecutive grants to one requester under contention (1..15)
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux2_rr_arbiter_4bit_if (both requesters + output)
// -----------------------------------------------------------------------------
module mux2_rr_arbiter_4bit
    import mux2_rr_arbiter_4bit_pkg::*;
#(
    parameter int BURST = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux2_rr_arbiter_4bit_if.slave  bus
);

    localparam int             CW        = cnt_width(BURST);
    localparam logic [CW-1:0]  BURST_CNT = CW'(BURST);
    localparam logic [CW-1:0]  ONE_CNT   = CW'(1);

    // Priority state: cur is the requester that owns the current burst and
    // cnt is how many grants it has taken in a row.
    logic          cur;
    logic [CW-1:0] cnt;

    // Output register stage.
    logic          out_valid_q;
    logic [3:0]    out_data_q;
    logic          out_src_q;

    logic          load;
    logic          gnt_valid;
    logic          gnt;
    logic          accept;
    logic [3:0]    mux_y;

    // Grant selection. The burst counter only matters when both requesters
    // are present; a lone requester always wins regardless of cnt.
    always_comb begin
        load      = !out_valid_q || bus.out_ready;
        gnt_valid = 1'b0;
        gnt       = SRC_0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_valid = 1'b1;
            gnt       = (cnt < BURST_CNT) ? cur : ~cur;
        end else if (bus.req0_valid) begin
            gnt_valid = 1'b1;
            gnt       = SRC_0;
        end else if (bus.req1_valid) begin
            gnt_valid = 1'b1;
            gnt       = SRC_1;
        end
    end

    // rst_n gates the readies so nothing is acknowledged while the block is
    // held in reset, even though load would otherwise be high.
    assign accept         = load && gnt_valid && rst_n;
    assign bus.req0_ready = accept && (gnt == SRC_0);
    assign bus.req1_ready = accept && (gnt == SRC_1);

    mux2by1_4bit u_mux (
        .op (gnt),
        .a  (bus.req0_data),
        .b  (bus.req1_data),
        .y  (mux_y)
    );

    // Output register and priority state. Everything freezes while the held
    // word is not being drained; a drain and a new load share the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 4'h0;
            out_src_q   <= SRC_0;
            cur         <= SRC_1;
            cnt         <= BURST_CNT;
        end else if (load) begin
            out_valid_q <= gnt_valid;
            if (gnt_valid) begin
                out_data_q <= mux_y;
                out_src_q  <= gnt;
                if (gnt == cur) begin
                    if (cnt < BURST_CNT) begin
                        cnt <= cnt + ONE_CNT;
                    end
                end else begin
                    cur <= gnt;
                    cnt <= ONE_CNT;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule
